// File: rtl/msg_sequencer_if.sv
// msg_sequencer_if: control/status bundle for the VDay message sequencer.
//   button, sec_tick, char_tick, hold : control inputs to the sequencer
//   enable   : overlay enables (intro overlays first, then message lines)
//   disp_len : packed per-line visible character counts
//   busy     : sequence in progress (intro or typing)
//   done     : full message shown
// master = controller/environment side, slave = sequencer side.
interface msg_sequencer_if #(
    parameter int unsigned NUM_INTRO = 3,
    parameter int unsigned NUM_LINES = 4,
    parameter int unsigned CNT_W     = 8
);
    logic                           button;
    logic                           sec_tick;
    logic                           char_tick;
    logic                           hold;
    logic [NUM_INTRO+NUM_LINES-1:0] enable;
    logic [NUM_LINES*CNT_W-1:0]     disp_len;
    logic                           busy;
    logic                           done;

    modport master (
        output button, sec_tick, char_tick, hold,
        input  enable, disp_len, busy, done
    );

    modport slave (
        input  button, sec_tick, char_tick, hold,
        output enable, disp_len, busy, done
    );
endinterface

// File: rtl/msg_sequencer.sv
// msg_sequencer: central sequencer for the VDay message screen.
// Waits for a button press, steps the intro overlays on sec_tick, then
// reveals the message lines one character per char_tick, line after line.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : msg_sequencer_if.slave (button/ticks/hold in; enable, disp_len,
//           busy, done out). All outputs come straight from registers.
module msg_sequencer #(
    parameter int unsigned                NUM_INTRO = 3,
    parameter int unsigned                NUM_LINES = 4,
    parameter int unsigned                CNT_W     = 8,
    parameter logic [NUM_LINES*CNT_W-1:0] LINE_LENS = {8'd24, 8'd23, 8'd21, 8'd18}
) (
    input logic             clk,
    input logic             reset,
    msg_sequencer_if.slave  bus
);

    localparam int unsigned EN_W   = NUM_INTRO + NUM_LINES;
    localparam int unsigned STEP_W = (NUM_INTRO > 1) ? $clog2(NUM_INTRO) : 1;
    localparam int unsigned LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INTRO,
        S_TYPE,
        S_DONE
    } state_t;

    state_t              state_q, state_n;
    logic [STEP_W-1:0]   step_q, step_n;
    logic [LINE_W-1:0]   line_q, line_n;
    logic [EN_W-1:0]     enable_q, enable_n;
    logic [CNT_W-1:0]    len_q [NUM_LINES];
    logic [CNT_W-1:0]    len_n [NUM_LINES];
    logic [CNT_W-1:0]    full_len [NUM_LINES];
    logic [CNT_W-1:0]    inc;
    logic                btn_q;
    logic                press;

    always_comb begin
        for (int unsigned k = 0; k < NUM_LINES; k++) begin
            full_len[k] = LINE_LENS[k*CNT_W +: CNT_W];
        end
    end

    // btn_q keeps tracking the button during hold, so an edge that happens
    // while frozen is consumed rather than replayed on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            line_q   <= '0;
            enable_q <= '0;
            btn_q    <= 1'b0;
            for (int unsigned k = 0; k < NUM_LINES; k++) begin
                len_q[k] <= '0;
            end
        end else begin
            state_q  <= state_n;
            step_q   <= step_n;
            line_q   <= line_n;
            enable_q <= enable_n;
            btn_q    <= bus.button;
            len_q    <= len_n;
        end
    end

    always_comb begin
        press    = bus.button & ~btn_q & ~bus.hold;
        state_n  = state_q;
        step_n   = step_q;
        line_n   = line_q;
        enable_n = enable_q;
        len_n    = len_q;
        inc      = '0;

        if (!bus.hold) begin
            unique case (state_q)
                // A press in IDLE or DONE restarts at intro step 0; any tick
                // in the same cycle is discarded.
                S_IDLE, S_DONE: begin
                    if (press) begin
                        state_n  = S_INTRO;
                        step_n   = '0;
                        line_n   = '0;
                        enable_n = EN_W'(1);
                        for (int unsigned k = 0; k < NUM_LINES; k++) begin
                            len_n[k] = '0;
                        end
                    end
                end
                S_INTRO: begin
                    if (bus.sec_tick) begin
                        if (step_q == STEP_W'(NUM_INTRO - 1)) begin
                            state_n  = S_TYPE;
                            enable_n = '1;
                            line_n   = '0;
                            for (int unsigned k = 0; k < NUM_LINES; k++) begin
                                len_n[k] = '0;
                            end
                        end else begin
                            step_n   = step_q + 1'b1;
                            // Enables are cumulative: shift in one more set bit.
                            enable_n = {enable_q[EN_W-2:0], 1'b1};
                        end
                    end
                end
                S_TYPE: begin
                    if (bus.char_tick) begin
                        // Lengths are at least 1 and each line stops exactly
                        // at its length, so the counter can never wrap.
                        inc           = len_q[line_q] + 1'b1;
                        len_n[line_q] = inc;
                        if (inc == full_len[line_q]) begin
                            if (line_q == LINE_W'(NUM_LINES - 1)) begin
                                state_n = S_DONE;
                            end else begin
                                line_n = line_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_LINES; k++) begin
            bus.disp_len[k*CNT_W +: CNT_W] = len_q[k];
        end
    end

    assign bus.enable = enable_q;
    assign bus.busy   = (state_q == S_INTRO) || (state_q == S_TYPE);
    assign bus.done   = (state_q == S_DONE);

endmodule

// File: tb/tb_msg_sequencer.sv
// tb_msg_sequencer: directed, table-driven bench for msg_sequencer with
// default parameters (3 intro overlays, lines of 18/21/23/24 characters).
module tb_msg_sequencer;

    logic clk;
    logic reset;

    msg_sequencer_if #(.NUM_INTRO(3), .NUM_LINES(4), .CNT_W(8)) bus ();

    msg_sequencer #(
        .NUM_INTRO(3),
        .NUM_LINES(4),
        .CNT_W(8),
        .LINE_LENS({8'd24, 8'd23, 8'd21, 8'd18})
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        btn;
        logic        sec;
        logic        chr;
        logic        hld;
        logic [6:0]  en;
        logic [31:0] len;
        logic        busy;
        logic        done;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] lens(input int l0, input int l1, input int l2, input int l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    function automatic vec_t mk(input logic rst, input logic btn, input logic sec,
                                input logic chr, input logic hld, input logic [6:0] en,
                                input logic [31:0] len, input logic busy, input logic done);
        vec_t v;
        v.rst = rst; v.btn = btn; v.sec = sec; v.chr = chr; v.hld = hld;
        v.en = en; v.len = len; v.busy = busy; v.done = done;
        return v;
    endfunction

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic apply(input logic rst, input logic btn, input logic sec,
                         input logic chr, input logic hld);
        reset         = rst;
        bus.button    = btn;
        bus.sec_tick  = sec;
        bus.char_tick = chr;
        bus.hold      = hld;
        @(posedge clk);
        #1;
    endtask

    task automatic repeat_apply(input int n, input logic btn, input logic sec,
                                input logic chr, input logic hld);
        for (int i = 0; i < n; i++) apply(1'b0, btn, sec, chr, hld);
    endtask

    task automatic check(input string name, input logic [6:0] en, input logic [31:0] len,
                         input logic busy, input logic done);
        checks++;
        if (bus.enable !== en) begin
            errors++;
            $display("FAIL %s enable got %b want %b", name, bus.enable, en);
        end
        checks++;
        if (bus.disp_len !== len) begin
            errors++;
            $display("FAIL %s disp_len got %h want %h", name, bus.disp_len, len);
        end
        checks++;
        if (bus.busy !== busy) begin
            errors++;
            $display("FAIL %s busy got %b want %b", name, bus.busy, busy);
        end
        checks++;
        if (bus.done !== done) begin
            errors++;
            $display("FAIL %s done got %b want %b", name, bus.done, done);
        end
    endtask

    initial begin
        // rst btn sec chr hld | enable len busy done
        for (int i = 0; i < 3; i++) vecs[i] = mk(1, 0, 0, 0, 0, 7'b0000000, '0, 0, 0);
        for (int i = 3; i < 13; i++)
            vecs[i] = mk(0, 0, (i % 2 == 1), (i % 2 == 0), 0, 7'b0000000, '0, 0, 0);
        vecs[13] = mk(0, 1, 0, 0, 0, 7'b0000001, '0, 1, 0); // press -> intro step 0
        vecs[14] = mk(0, 1, 0, 0, 0, 7'b0000001, '0, 1, 0); // level held, no new edge
        vecs[15] = mk(0, 0, 0, 0, 0, 7'b0000001, '0, 1, 0);
        vecs[16] = mk(0, 0, 1, 0, 0, 7'b0000011, '0, 1, 0); // step 1
        vecs[17] = mk(0, 0, 0, 0, 0, 7'b0000011, '0, 1, 0);
        vecs[18] = mk(0, 1, 1, 0, 0, 7'b0000111, '0, 1, 0); // press ignored in intro
        vecs[19] = mk(0, 0, 0, 0, 0, 7'b0000111, '0, 1, 0);
        vecs[20] = mk(0, 0, 0, 1, 0, 7'b0000111, '0, 1, 0); // char_tick ignored in intro
        vecs[21] = mk(0, 0, 1, 0, 1, 7'b0000111, '0, 1, 0); // hold drops sec_tick
        vecs[22] = mk(0, 0, 1, 0, 0, 7'b1111111, '0, 1, 0); // into typing
        vecs[23] = mk(0, 0, 1, 0, 0, 7'b1111111, '0, 1, 0); // sec_tick ignored in typing
        vecs[24] = mk(0, 0, 0, 1, 0, 7'b1111111, lens(1, 0, 0, 0), 1, 0);

        reset = 1'b1;
        bus.button = 1'b0; bus.sec_tick = 1'b0; bus.char_tick = 1'b0; bus.hold = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].rst, vecs[i].btn, vecs[i].sec, vecs[i].chr, vecs[i].hld);
            check($sformatf("vec%0d", i), vecs[i].en, vecs[i].len, vecs[i].busy, vecs[i].done);
        end

        // Line 0 boundary: 18 ticks total fill line 0, 19th starts line 1.
        repeat_apply(17, 0, 0, 1, 0);
        check("line0_full", 7'b1111111, lens(18, 0, 0, 0), 1, 0);
        apply(0, 0, 0, 1, 0);
        check("line1_start", 7'b1111111, lens(18, 1, 0, 0), 1, 0);

        // Hold freezes typing; ticks and a button edge during hold are dropped.
        repeat_apply(4, 0, 0, 1, 1);
        apply(0, 1, 1, 1, 1);
        check("hold_freeze", 7'b1111111, lens(18, 1, 0, 0), 1, 0);
        apply(0, 0, 0, 1, 0);
        check("hold_release", 7'b1111111, lens(18, 2, 0, 0), 1, 0);

        // 86 ticks total complete the message; one short of it still busy.
        repeat_apply(65, 0, 0, 1, 0);
        check("last_char_pending", 7'b1111111, lens(18, 21, 23, 23), 1, 0);
        apply(0, 0, 0, 1, 0);
        check("complete", 7'b1111111, lens(18, 21, 23, 24), 0, 1);
        repeat_apply(3, 0, 0, 1, 0);
        apply(0, 0, 1, 1, 0);
        check("done_stable", 7'b1111111, lens(18, 21, 23, 24), 0, 1);

        // Press in DONE (with a simultaneous tick) restarts at intro step 0.
        apply(0, 1, 0, 1, 0);
        check("restart", 7'b0000001, '0, 1, 0);
        apply(0, 0, 0, 0, 0);
        check("restart_hold", 7'b0000001, '0, 1, 0);

        // Reset mid-intro, then press together with sec_tick in IDLE.
        apply(1, 0, 1, 0, 0);
        check("reset_intro", 7'b0000000, '0, 0, 0);
        apply(0, 1, 1, 0, 0);
        check("press_with_tick", 7'b0000001, '0, 1, 0);
        apply(0, 0, 0, 0, 0);
        repeat_apply(3, 0, 1, 0, 0);
        check("type_again", 7'b1111111, '0, 1, 0);

        // Reset while typing line 2.
        repeat_apply(49, 0, 0, 1, 0);
        check("line2_mid", 7'b1111111, lens(18, 21, 10, 0), 1, 0);
        apply(1, 0, 0, 1, 0);
        check("reset_typing", 7'b0000000, '0, 0, 0);
        apply(0, 0, 1, 1, 0);
        check("idle_after_reset", 7'b0000000, '0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
